// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
package mux_rr_arbiter_pkg;

  localparam int NUM_REQ       = 4;
  localparam int DEF_DATA_W    = 4;
  localparam int DEF_BURST_LEN = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } st_e;

  typedef logic [NUM_REQ-1:0] req_t;
  typedef logic [1:0]         idx_t;

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester/consumer bundle; the arbiter sits on the slave side.
interface mux_rr_arbiter_if
  import mux_rr_arbiter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  req_t                            req;
  logic [NUM_REQ-1:0][DATA_W-1:0]  data_in;
  logic                            out_ready;
  req_t                            gnt;
  idx_t                            sel;
  logic                            out_valid;
  logic [DATA_W-1:0]               out_data;
  req_t                            ack;

  modport master (
    output req, data_in, out_ready,
    input  gnt, sel, out_valid, out_data, ack
  );

  modport slave (
    input  req, data_in, out_ready,
    output gnt, sel, out_valid, out_data, ack
  );
endinterface

// File: rtl/mux_rr_arbiter_mux4.sv
// 4:1 word multiplexer used as the shared datapath.
module mux_rr_arbiter_mux4 #(
  parameter int W = 4
) (
  input  logic [3:0][W-1:0] d,
  input  logic [1:0]        s,
  output logic [W-1:0]      y
);
  assign y = d[s];
endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter: grants one of four requesters for a bounded burst,
// steers the shared mux and presents the word on a valid/ready port.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int CNT_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mux_rr_arbiter_if.slave   bus
);

  st_e              state, state_n;
  req_t             gnt, gnt_n;
  idx_t             sel, sel_n;
  idx_t             ptr, ptr_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             out_valid, xfer;
  logic [DATA_W-1:0] mux_y;

  // First asserted request after the last-served index, wrapping; the
  // descending loop leaves the nearest hit as the final assignment.
  function automatic idx_t rr_pick(input req_t r, input idx_t p);
    idx_t k;
    rr_pick = p;
    for (int i = NUM_REQ; i >= 1; i--) begin
      k = p + idx_t'(i);
      if (r[k]) rr_pick = k;
    end
  endfunction

  mux_rr_arbiter_mux4 #(.W(DATA_W)) u_mux (
    .d (bus.data_in),
    .s (sel),
    .y (mux_y)
  );

  assign out_valid     = (state == ST_BUSY) && bus.req[sel];
  assign xfer          = out_valid && bus.out_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = mux_y;
  assign bus.ack       = xfer ? gnt : '0;
  assign bus.gnt       = gnt;
  assign bus.sel       = sel;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      gnt   <= '0;
      sel   <= '0;
      ptr   <= idx_t'(NUM_REQ - 1);
      cnt   <= '0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      sel   <= sel_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    sel_n   = sel;
    ptr_n   = ptr;
    cnt_n   = cnt;
    case (state)
      ST_IDLE: begin
        if (|bus.req) begin
          sel_n   = rr_pick(bus.req, ptr);
          gnt_n   = req_t'(1) << sel_n;
          cnt_n   = '0;
          state_n = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Burst end takes precedence over a simultaneous owner release.
        if (xfer && cnt == CNT_W'(BURST_LEN - 1)) begin
          state_n = ST_IDLE;
          ptr_n   = sel;
          gnt_n   = '0;
          cnt_n   = '0;
        end else if (!bus.req[sel]) begin
          state_n = ST_IDLE;
          ptr_n   = sel;
          gnt_n   = '0;
        end else if (xfer) begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed scenarios plus randomized traffic against a behavioural
// owner/last-served model of the round-robin arbiter.
module tb_mux_rr_arbiter;
  import mux_rr_arbiter_pkg::*;

  localparam int BL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter_if #(.DATA_W(4)) bus ();

  mux_rr_arbiter #(.DATA_W(4), .BURST_LEN(BL), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Model: who owns the datapath, who was served last, acks in this grant.
  int  own   = -1;
  int  last  = 3;
  int  nack  = 0;
  int  selm  = 0;
  bit  known = 1'b0;

  always @(negedge clk) begin
    int  eg, ea;
    bit  ev, found;
    if (known) begin
      eg = (own >= 0) ? (1 << own) : 0;
      ev = (own >= 0) && bus.req[own];
      ea = (ev && bus.out_ready) ? eg : 0;
      chk("gnt", 32'(bus.gnt), 32'(eg));
      chk("sel", 32'(bus.sel), 32'(selm));
      chk("out_valid", 32'(bus.out_valid), 32'(ev));
      chk("ack", 32'(bus.ack), 32'(ea));
      if (ev) chk("out_data", 32'(bus.out_data), 32'(bus.data_in[own]));
    end
    if (!rst_n) begin
      own = -1; last = 3; nack = 0; selm = 0; known = 1'b1;
    end else if (known) begin
      if (own < 0) begin
        found = 1'b0;
        for (int d = 1; d <= 4; d++) begin
          if (!found && bus.req[(last + d) % 4]) begin
            found = 1'b1;
            own   = (last + d) % 4;
            selm  = own;
            nack  = 0;
          end
        end
      end else if (bus.req[own] && bus.out_ready && nack == BL - 1) begin
        last = own; own = -1;
      end else if (!bus.req[own]) begin
        last = own; own = -1;
      end else if (bus.out_ready) begin
        nack++;
      end
    end
  end

  bit bp [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    bus.req       = '0;
    bus.out_ready = 1'b1;
    bus.data_in   = 16'($urandom);

    // Reset then a lone requester 2 with word A.
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; bus.req = 4'b0100; bus.data_in[2] = 4'hA;
    @(negedge clk) chk("s1_idle_gnt", 32'(bus.gnt), 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("s1_gnt", 32'(bus.gnt), 32'h4);
      chk("s1_sel", 32'(bus.sel), 32'h2);
      chk("s1_ack", 32'(bus.ack), 32'h4);
      chk("s1_data", 32'(bus.out_data), 32'hA);
    end
    @(posedge clk); #1;
    @(negedge clk) chk("s1_gap", 32'(bus.gnt), 32'h0);
    @(posedge clk); #1;
    @(negedge clk) chk("s1_regrant", 32'(bus.gnt), 32'h4);

    // Rotation with everyone requesting.
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; bus.req = 4'b1111;
    @(negedge clk) chk("s2_idle", 32'(bus.gnt), 32'h0);
    for (int g = 0; g < 5; g++) begin
      for (int b = 0; b < 4; b++) begin
        @(posedge clk); #1;
        @(negedge clk);
        chk("s2_gnt", 32'(bus.gnt), 32'(1 << (g % 4)));
        chk("s2_ack", 32'(bus.ack), 32'(1 << (g % 4)));
      end
      @(posedge clk); #1;
      @(negedge clk) chk("s2_gap", 32'(bus.gnt), 32'h0);
    end

    // Backpressure on requester 1.
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; bus.req = 4'b0010;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 bus.out_ready = bp[i];
      @(negedge clk);
      chk("s3_gnt", 32'(bus.gnt), 32'h2);
      chk("s3_ack", 32'(bus.ack), bp[i] ? 32'h2 : 32'h0);
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(negedge clk) chk("s3_release", 32'(bus.gnt), 32'h0);

    // Early release by requester 3 with requester 0 waiting.
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; bus.req = 4'b1000;
    @(negedge clk);
    @(posedge clk); #1 bus.req = 4'b1001;
    @(negedge clk) chk("s4_ack1", 32'(bus.ack), 32'h8);
    @(posedge clk); #1;
    @(negedge clk) chk("s4_ack2", 32'(bus.ack), 32'h8);
    @(posedge clk); #1 bus.req = 4'b0001;
    @(negedge clk);
    chk("s4_drop_ack", 32'(bus.ack), 32'h0);
    chk("s4_drop_valid", 32'(bus.out_valid), 32'h0);
    @(posedge clk); #1;
    @(negedge clk) chk("s4_idle", 32'(bus.gnt), 32'h0);
    @(posedge clk); #1;
    @(negedge clk) chk("s4_next", 32'(bus.gnt), 32'h1);

    // Reset in the middle of requester 2's burst.
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; bus.req = 4'b0100;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk) chk("s5_ack1", 32'(bus.ack), 32'h4);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; bus.req = 4'b0101;
    @(negedge clk);
    chk("s5_gnt", 32'(bus.gnt), 32'h0);
    chk("s5_ack", 32'(bus.ack), 32'h0);
    chk("s5_valid", 32'(bus.out_valid), 32'h0);
    @(posedge clk); #1;
    @(negedge clk) chk("s5_first", 32'(bus.gnt), 32'h1);

    // Random traffic; requests toggle occasionally, rare resets.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 5) == 0) bus.req[i] = ~bus.req[i];
      bus.out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++)
        if (!bus.req[i] || $urandom_range(0, 7) == 0) bus.data_in[i] = 4'($urandom);
      rst_n = ($urandom_range(0, 199) != 0);
    end

    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
